// File: rtl/sim_checker_arbiter.sv
// Round-robin arbiter funnelling up to four monitor taps into one registered checker stream.
// Define SIM_ARB_STATS_EN to add per-source saturating grant counters on port grant_count.
module sim_checker_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned SRC_ID_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              s_valid,
    output logic [NUM_SRC-1:0]              s_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_SRC-1:0]              s_done,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [SRC_ID_WIDTH-1:0]         m_src,
    output logic                            all_done
`ifdef SIM_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]           grant_count
`endif
);

    localparam int unsigned NumSlots = 1 << SRC_ID_WIDTH;

    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [SRC_ID_WIDTH-1:0] m_src_q, m_src_d;
    logic [SRC_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]      done_seen_q, done_seen_d;
    logic                    all_done_q, all_done_d;

    logic                    load;
    logic                    xfer;
    logic                    gnt_found;
    logic [SRC_ID_WIDTH-1:0] gnt_idx;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic [NumSlots-1:0]     elig_slots;
    logic [NumSlots-1:0]     done_slots;

    assign load = !m_valid_q || m_ready;
    assign xfer = load && gnt_found;

    // Unused tag slots are never eligible and always count as finished.
    always_comb begin
        elig_slots = '0;
        elig_slots[NUM_SRC-1:0] = s_valid & ~done_seen_q;
        done_slots = '1;
        done_slots[NUM_SRC-1:0] = done_seen_q;
    end

    always_comb begin
        int unsigned slot;
        slot      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            slot = 32'(rr_ptr_q) + k;
            if (slot >= NUM_SRC) begin
                slot = slot - NUM_SRC;
            end
            if (!gnt_found && elig_slots[SRC_ID_WIDTH'(slot)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_ID_WIDTH'(slot);
            end
        end
    end

    assign gnt_data = s_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        s_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            s_ready[i] = !rst && xfer && (gnt_idx == SRC_ID_WIDTH'(i));
        end
    end

    always_comb begin
        int unsigned nxt;
        nxt       = 32'(gnt_idx) + 1;
        if (nxt >= NUM_SRC) begin
            nxt = 0;
        end
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (load) begin
            m_valid_d = gnt_found;
            if (gnt_found) begin
                m_data_d = gnt_data;
                m_src_d  = gnt_idx;
                rr_ptr_d = SRC_ID_WIDTH'(nxt);
            end
        end
        // Exclusion takes effect from the cycle after s_done, so a same-cycle tuple still passes.
        done_seen_d = done_seen_q | s_done;
        all_done_d  = all_done_q || (&done_slots && !m_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_src_q     <= '0;
            rr_ptr_q    <= '0;
            done_seen_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_src_q     <= m_src_d;
            rr_ptr_q    <= rr_ptr_d;
            done_seen_q <= done_seen_d;
            all_done_q  <= all_done_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_src    = m_src_q;
    assign all_done = all_done_q;

`ifdef SIM_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_SRC];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (rst) begin
                grant_cnt_q[i] <= '0;
            end else if (xfer && (gnt_idx == SRC_ID_WIDTH'(i)) && (grant_cnt_q[i] != '1)) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant_count[i*32 +: 32] = grant_cnt_q[i];
        end
    end
`endif

    a_ready_onehot0: assert property (@(posedge clk) $onehot0(s_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_src)));

endmodule

// File: tb/tb_sim_checker_arbiter.sv
// Scoreboard bench for sim_checker_arbiter: a rotating-priority reference model predicts
// every transfer, and a negedge monitor compares the registered output stream against it.
module tb_sim_checker_arbiter;

    localparam int NS = 4;
    localparam int DW = 256;
    localparam int SW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NS-1:0]       s_valid = '0;
    logic [NS-1:0]       s_ready;
    logic [NS*DW-1:0]    s_data = '0;
    logic [NS-1:0]       s_done = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [DW-1:0]       m_data;
    logic [SW-1:0]       m_src;
    logic                all_done;
`ifdef SIM_ARB_STATS_EN
    logic [NS*32-1:0]    grant_count;
`endif

    sim_checker_arbiter #(
        .NUM_SRC      (NS),
        .DATA_WIDTH   (DW),
        .SRC_ID_WIDTH (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_done   (s_done),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_src    (m_src),
        .all_done (all_done)
`ifdef SIM_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    // Reference model: who was served last, which sources are finished, whether a tuple waits.
    int            last_m;
    logic [NS-1:0] done_m;
    logic          out_full_m;
    logic          all_done_m;
    int unsigned   cnt_m [NS];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_m     = NS - 1;
        done_m     = '0;
        out_full_m = 1'b0;
        all_done_m = 1'b0;
        for (int i = 0; i < NS; i++) cnt_m[i] = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NS * DW / 32; i++) s_data[i*32 +: 32] = $urandom;
    endtask

    // Predict this cycle's transfer just before the rising edge, then return after the edge.
    task automatic step();
        int   g;
        int   idx;
        logic ld;
        @(negedge clk);
        #1;
        if (rst) begin
            chk("s_ready_in_reset", DW'(s_ready), '0);
            model_reset();
        end else begin
            g  = -1;
            ld = !out_full_m || m_ready;
            if (ld) begin
                for (int k = 1; k <= NS; k++) begin
                    idx = (last_m + k) % NS;
                    if (g < 0 && s_valid[idx] && !done_m[idx]) g = idx;
                end
            end
            chk("s_ready", DW'(s_ready), (g >= 0) ? (DW'(1) << g) : '0);
            if (g >= 0) begin
                exp_q.push_back({SW'(g), s_data[g*DW +: DW]});
                last_m = g;
                cnt_m[g]++;
            end
            all_done_m = all_done_m || (&done_m && !out_full_m);
            done_m     = done_m | s_done;
            out_full_m = (g >= 0) || (out_full_m && !m_ready);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", DW'(m_valid), DW'(exp_q.size() != 0));
            chk("all_done", DW'(all_done), DW'(all_done_m));
            if (exp_q.size() != 0) begin
                chk("m_src", DW'(m_src), DW'(exp_q[0].src));
                chk("m_data", m_data, exp_q[0].data);
                if (m_ready) void'(exp_q.pop_front());
            end
`ifdef SIM_ARB_STATS_EN
            for (int i = 0; i < NS; i++) begin
                chk("grant_count", DW'(grant_count[i*32 +: 32]), DW'(cnt_m[i]));
            end
`endif
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        chk("rst_m_valid", DW'(m_valid), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_src", DW'(m_src), '0);
        chk("rst_all_done", DW'(all_done), '0);
`ifdef SIM_ARB_STATS_EN
        chk("rst_grant_count", DW'(grant_count), '0);
`endif
        rst     = 1'b0;
        s_done  = '0;
        s_valid = '0;
    endtask

    initial begin
        model_reset();
        reset_dut();

        // Every source busy: strict 0,1,2,3 rotation with a beat every cycle.
        s_valid = '1;
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rand_data();
            step();
            chk("rotation_src", DW'(m_src), DW'(k % NS));
            chk("rotation_valid", DW'(m_valid), DW'(1));
        end

        // Lone source 2 with a recognisable pattern.
        s_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            s_data[2*DW +: DW] = {{31{8'hA5}}, 8'(k)};
            step();
            chk("solo_src", DW'(m_src), DW'(2));
            chk("solo_data", m_data, {{31{8'hA5}}, 8'(k)});
        end

        // Back-pressure: output must freeze and nothing may be accepted.
        s_valid = '1;
        rand_data();
        step();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step();
            chk("stall_s_ready", DW'(s_ready), '0);
        end
        m_ready = 1'b1;

        // Random traffic and random back-pressure.
        for (int k = 0; k < 150; k++) begin
            s_valid = NS'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        // Source 1 finishes while 0 and 3 keep pushing.
        m_ready = 1'b1;
        s_done  = 4'b0010;
        s_valid = 4'b1011;
        for (int k = 0; k < 12; k++) begin
            rand_data();
            step();
            if (k >= 1) chk("src1_excluded", DW'(m_src == 2'd1), '0);
        end

        // Everyone finishes; all_done must follow the final drain and then stick.
        s_done  = '1;
        s_valid = NS'($urandom);
        rand_data();
        step();
        s_valid = '1;
        begin
            int waited = 0;
            while (!all_done && waited < 10) begin
                step();
                waited++;
            end
            chk("all_done_reached", DW'(all_done), DW'(1));
        end
        for (int k = 0; k < 5; k++) begin
            m_ready = $urandom_range(0, 1);
            step();
        end
        m_ready = 1'b1;

        // Reset while a tuple sits in the output stage.
        reset_dut();
        s_valid = '1;
        m_ready = 1'b0;
        rand_data();
        step();
        step();
        chk("pre_rst_valid", DW'(m_valid), DW'(1));
        reset_dut();
        s_valid = '1;
        m_ready = 1'b1;
        rand_data();
        step();
        chk("post_rst_src", DW'(m_src), '0);
        for (int k = 0; k < 20; k++) begin
            s_valid = NS'($urandom);
            m_ready = $urandom_range(0, 1);
            rand_data();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_checker_arbiter.md
# sim_checker_arbiter

Round-robin arbiter that shares one simulation checker input stream between up to four monitored datapath taps, such as PIFO enqueue, dequeue and root-output streams. It accepts valid/ready tuples from each source and forwards one tuple per transfer through a single registered output stage, tagged with the source index. It tracks per-source end-of-stream so the downstream checker receives a single `all_done` indication. It sits between the DUT monitor taps and the checker in the PIFO regression benches.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, legal range 1..4.
- `DATA_WIDTH`, 256: tuple width per source.
- `SRC_ID_WIDTH`, 2: width of the source tag; must satisfy 2^SRC_ID_WIDTH >= NUM_SRC.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  NUM_SRC  per-source tuple valid.
- `s_ready`  out  NUM_SRC  per-source accept; one-hot or zero.
- `s_data`  in  NUM_SRC*DATA_WIDTH  flattened tuples; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_done`  in  NUM_SRC  level; the source has no further tuples.
- `m_valid`  out  1  output tuple valid.
- `m_ready`  in  1  checker accept.
- `m_data`  out  DATA_WIDTH  granted tuple.
- `m_src`  out  SRC_ID_WIDTH  index of the source that produced `m_data`.
- `all_done`  out  1  every source is done and the output stage is empty.

## Operation
- Output stage is a single register holding `m_valid`, `m_data` and `m_src`.
- `load` = `!m_valid | m_ready`. The stage may capture a new tuple in the same cycle it drains.
- Grant is combinational: when `load` is high, grant the first i with `s_valid[i]`, searching from `rr_ptr` upward and wrapping modulo NUM_SRC. `s_ready[i]` = grant[i] & `load`.
- On a transfer from source g:
  - `m_data` <= the slice of `s_data` for source g.
  - `m_src` <= g.
  - `m_valid` <= 1.
  - `rr_ptr` <= (g+1) mod NUM_SRC.
- If `load` is high and no source is valid: `m_valid` <= 0, and `rr_ptr` is unchanged.
- If `m_valid` is high and `m_ready` is low: the output stage holds, and all `s_ready` are 0.
- `done_seen[i]` is a sticky flag set on `s_done[i]`. A source with `done_seen` set is excluded from arbitration.
- `all_done` = &`done_seen` & `!m_valid`, registered. Once it asserts it stays high until reset.
- Sources with index >= NUM_SRC do not exist; their `done_seen` bits are forced to 1.
- Simultaneous `s_valid[i]` and `s_done[i]` with i granted: the tuple transfers, then the source is excluded from the next cycle on.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_src`=0, `all_done`=0.
  - `rr_ptr`=0, `done_seen`=0.
  - `s_ready`=0 while `rst` is high.
- Latency: a tuple accepted at edge N appears on `m_*` after edge N. One cycle, source to checker.
- Throughput: one tuple per cycle with `m_ready` held high.
- Fairness: a continuously valid source waits at most NUM_SRC-1 transfers.
- `all_done` rises one cycle after the last output drains.
- Reset asserted mid-transfer discards the held tuple; no partial state survives reset.

## Configuration
- `SIM_ARB_STATS_EN` defined:
  - Adds one 32-bit saturating grant counter per source.
  - Adds output port `grant_count` [NUM_SRC*32-1:0], flattened like `s_data`.
  - Counters reset to 0 and increment on each transfer from that source.
- Not defined: the counters and the port are absent.

## Test plan
- All 4 sources valid continuously, `m_ready`=1. Required: `m_src` sequence 0,1,2,3,0,1... with no idle cycle.
- Only source 2 valid, with data 0xA5..; `m_ready`=1. Required: every beat has `m_src`=2, and `m_data` matches the input one cycle later.
- `m_ready`=0 for 5 cycles while `m_valid`=1. Required: `m_data` and `m_src` are stable, and `s_ready` is 0x0 throughout.
- Source 1 asserts `s_done` while sources 0 and 3 stay valid. Required: source 1 is never granted again, and the rotation becomes 0,3,0,3.
- All sources assert `s_done`, then the last tuple drains. Required: `all_done`=1 exactly one cycle after the final `m_valid&m_ready`, and it stays high.
- `rst` pulsed while `m_valid`=1 with `SIM_ARB_STATS_EN` defined. Required: all outputs and counters read 0 on the next cycle, and `rr_ptr` restarts at source 0.
